// File: rtl/serial_add_seq.sv
// serial_add_seq
// Bit-serial addition sequencer wrapped around an external 1-bit full-adder
// slice. Two WIDTH-bit operands and a carry-in are accepted on start. They are
// fed to the slice LSB-first, one bit per clock, while the running carry is
// held here. The returned sum bits are gathered into a parallel result
// together with carry-out and two's-complement overflow.
//
// Ports:
//   clk      - system clock, all state on rising edge
//   rst      - synchronous, active-high reset
//   start    - begin an addition (honoured only when idle)
//   a, b     - WIDTH-bit operands, sampled on accepted start
//   cin      - carry-in, sampled on accepted start
//   fa_a     - operand A bit presented to the slice
//   fa_b     - operand B bit presented to the slice
//   fa_cin   - running carry presented to the slice
//   fa_s     - sum bit returned by the slice (combinational)
//   fa_cout  - carry bit returned by the slice (combinational)
//   busy     - high while an addition is in progress
//   done     - one-cycle pulse, sum/cout/ovf valid
//   sum      - parallel result
//   cout     - final carry-out
//   ovf      - two's-complement overflow
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cap_a_msb;
    logic             cap_b_msb;
    logic             cout_q;
    logic             ovf_q;
    logic             last_bit;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // The partial result only keeps the WIDTH-1 bits already collected; the
    // bit arriving this cycle is concatenated on top, so on the final RUN edge
    // res_next is the complete sum.
    assign res_next = {fa_s, res_sh};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE always lasts a single cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. The visible sum/cout/ovf registers are only written on the
    // last RUN edge, so they hold the previous result throughout a new
    // addition and are valid exactly when done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa        <= '0;
            sb        <= '0;
            res_sh    <= '0;
            sum_q     <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            cap_a_msb <= 1'b0;
            cap_b_msb <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa        <= a;
                        sb        <= b;
                        carry     <= cin;
                        cnt       <= '0;
                        res_sh    <= '0;
                        cap_a_msb <= a[WIDTH-1];
                        cap_b_msb <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    res_sh <= res_next[WIDTH-1:1];
                    carry  <= fa_cout;
                    sa     <= {1'b0, sa[WIDTH-1:1]};
                    sb     <= {1'b0, sb[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum_q  <= res_next;
                        cout_q <= fa_cout;
                        ovf_q  <= (cap_a_msb == cap_b_msb) && (fa_s != cap_a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slice operands are forced low outside RUN so the slice sees quiet
    // inputs while idle.
    always_comb begin
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        if (state == RUN) begin
            fa_a   = sa[0];
            fa_b   = sb[0];
            fa_cin = carry;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
